// File: rtl/rvv_fifo_rd_serializer.sv
// Read-side drain for the RVV open FIFO: pops one DWIDTH entry and streams it LSB-first as OWIDTH beats.
// Optional stall counter enabled by defining RVV_FIFO_RD_SER_STALL_CNT_EN.
module rvv_fifo_rd_serializer #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef RVV_FIFO_RD_SER_STALL_CNT_EN
  ,
  input  logic              stall_cnt_clr,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int RATIO  = DWIDTH / OWIDTH;
  localparam int CWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(RATIO - 1);
  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;

  if ((DWIDTH % OWIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
    $error("rvv_fifo_rd_serializer: DWIDTH must be a positive multiple of OWIDTH");
  end

  logic              hold_valid;
  logic [DWIDTH-1:0] shift_q;
  logic [DWIDTH-1:0] shift_nxt;
  logic [CWIDTH-1:0] beat_cnt;
  logic              accept;
  logic              done;

  // With a single beat per entry every accept is also done, so no shift path is needed.
  if (RATIO > 1) begin : g_shift
    assign shift_nxt = {{OWIDTH{1'b0}}, shift_q[DWIDTH-1:OWIDTH]};
  end else begin : g_noshift
    assign shift_nxt = '0;
  end

  assign out_valid = hold_valid;
  assign busy      = hold_valid;
  assign out_data  = shift_q[OWIDTH-1:0];
  assign out_last  = (hold_valid == STREAM) && (beat_cnt == LAST_BEAT);
  assign accept    = hold_valid & out_ready;
  assign done      = accept & out_last;
  // Refill in the same cycle the last beat leaves, so entries stream without a bubble.
  assign fifo_pop  = ~rst & ~fifo_empty & ((hold_valid == IDLE) | done);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= IDLE;
      beat_cnt   <= '0;
      shift_q    <= '0;
    end else if (fifo_pop) begin
      hold_valid <= STREAM;
      beat_cnt   <= '0;
      shift_q    <= fifo_data;
    end else if (done) begin
      hold_valid <= IDLE;
      beat_cnt   <= '0;
    end else if (accept) begin
      shift_q    <= shift_nxt;
      beat_cnt   <= beat_cnt + CWIDTH'(1);
    end
  end

`ifdef RVV_FIFO_RD_SER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
